cdb_arbiter: RTL and testbench

- Shares the single result/common data bus (tag + value) between all functional units that write results back to the reorder buffer and reservation stations (ALU, load/store unit, spare unit).
- Each requester gets a one-entry holding buffer.
- A round-robin scheduler picks one result per cycle and drives it onto a registered bus.
- Uncontended latency is 1 cycle. A flush clears all in-flight results.

---
 rtl/cdb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared constants for the common data bus arbiter: default tag/value widths,
// the "no result" tag, functional-unit requester indices, and the round-robin
// pointer increment helper.
// -----------------------------------------------------------------------------
package cdb_pkg;

    localparam int TAG_W  = 3;
    localparam int XLEN   = 32;
    localparam int NO_TAG = 0;

    // Requester slots on the bus
    localparam int FU_ALU = 0;
    localparam int FU_LSU = 1;
    localparam int FU_AUX = 2;
    localparam int NUM_FU = 3;

    // Next round-robin start position after index idx was granted
    function automatic int rr_next(input int idx, input int n);
        if (idx >= n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant: the first set request at or after
// i_ptr (wrapping) receives the one-hot grant.
//   i_req   [N-1:0]      request mask
//   i_ptr   [PTR_W-1:0]  search start index (must be < N)
//   o_grant [N-1:0]      one-hot grant, zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] w_rot_req;
    logic [N-1:0] w_rot_gnt;

    // Rotate so that bit 0 is the requester at i_ptr, then take the lowest set
    // bit and rotate the grant back into place.
    assign w_rot_req = N'({i_req, i_req} >> i_ptr);
    assign w_rot_gnt = w_rot_req & (~w_rot_req + ONE);
    assign o_grant   = N'(({w_rot_gnt, w_rot_gnt} << i_ptr) >> N);

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the registered common data bus between NUM_REQ functional units.
// Each requester owns a one-entry holding buffer; a round-robin scheduler
// picks one candidate per cycle and registers it onto the bus.
//   clk, rst(async, active-low), flush (sync squash of everything in flight)
//   req_valid/req_tag/req_value  per-requester result, packed by index
//   req_ready                    requester may present a new result
//   cdb_num/cdb_value/cdb_src    registered broadcast; cdb_num==0 means idle
//   busy                         some holding buffer is occupied
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ = cdb_pkg::NUM_FU,
    parameter int TAG_W   = cdb_pkg::TAG_W,
    parameter int XLEN    = cdb_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic [NUM_REQ*XLEN-1:0]  req_value,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [TAG_W-1:0]         cdb_num,
    output logic [XLEN-1:0]          cdb_value,
    output logic [NUM_REQ-1:0]       cdb_src,
    output logic                     busy
);
    import cdb_pkg::*;

    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam logic [TAG_W-1:0] NO_TAG_W = TAG_W'(NO_TAG);

    logic [NUM_REQ-1:0] r_buf_valid;
    logic [TAG_W-1:0]   r_buf_tag   [NUM_REQ];
    logic [XLEN-1:0]    r_buf_value [NUM_REQ];
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [TAG_W-1:0]   r_cdb_num;
    logic [XLEN-1:0]    r_cdb_value;
    logic [NUM_REQ-1:0] r_cdb_src;
    logic               r_busy;

    logic [TAG_W-1:0]   w_in_tag    [NUM_REQ];
    logic [XLEN-1:0]    w_in_value  [NUM_REQ];
    logic [TAG_W-1:0]   w_cand_tag  [NUM_REQ];
    logic [XLEN-1:0]    w_cand_value[NUM_REQ];
    logic [NUM_REQ-1:0] w_accept;
    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_buf_valid_nxt;
    logic [TAG_W-1:0]   w_win_tag;
    logic [XLEN-1:0]    w_win_value;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_rr_next;

    // Per-requester candidate: a buffered entry shadows new input (ready is low then)
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_in_tag[i]     = req_tag[i*TAG_W +: TAG_W];
            w_in_value[i]   = req_value[i*XLEN +: XLEN];
            w_accept[i]     = req_valid[i] & ~r_buf_valid[i] & (w_in_tag[i] != NO_TAG_W);
            w_cand[i]       = r_buf_valid[i] | w_accept[i];
            w_cand_tag[i]   = r_buf_valid[i] ? r_buf_tag[i]   : w_in_tag[i];
            w_cand_value[i] = r_buf_valid[i] ? r_buf_value[i] : w_in_value[i];
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // One-hot grant selects the winning candidate with an AND-OR mux
    always_comb begin
        w_win_tag   = '0;
        w_win_value = '0;
        w_win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_tag   = w_win_tag   | (w_cand_tag[i]   & {TAG_W{w_grant[i]}});
            w_win_value = w_win_value | (w_cand_value[i] & {XLEN{w_grant[i]}});
            w_win_idx   = w_win_idx   | (PTR_W'(i)       & {PTR_W{w_grant[i]}});
        end
    end

    // Every non-winning candidate ends up (or stays) buffered unless flushed
    always_comb begin
        w_buf_valid_nxt = {NUM_REQ{~flush}} & w_cand & ~w_grant;
        w_rr_next       = PTR_W'(rr_next(int'(w_win_idx), NUM_REQ));
    end

    // Holding buffers and the registered busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= '0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_buf_tag[i]   <= '0;
                r_buf_value[i] <= '0;
            end
        end else begin
            r_buf_valid <= w_buf_valid_nxt;
            r_busy      <= |w_buf_valid_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_buf_valid_nxt[i]) begin
                    r_buf_tag[i]   <= w_cand_tag[i];
                    r_buf_value[i] <= w_cand_value[i];
                end else begin
                    r_buf_tag[i]   <= r_buf_tag[i];
                    r_buf_value[i] <= r_buf_value[i];
                end
            end
        end
    end

    // Registered bus and round-robin pointer; flush idles the bus but keeps the pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb_num   <= '0;
            r_cdb_value <= '0;
            r_cdb_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (flush) begin
            r_cdb_num   <= '0;
            r_cdb_value <= r_cdb_value;
            r_cdb_src   <= '0;
            r_rr_ptr    <= r_rr_ptr;
        end else if (|w_cand) begin
            r_cdb_num   <= w_win_tag;
            r_cdb_value <= w_win_value;
            r_cdb_src   <= w_grant;
            r_rr_ptr    <= w_rr_next;
        end else begin
            r_cdb_num   <= '0;
            r_cdb_value <= r_cdb_value;
            r_cdb_src   <= '0;
            r_rr_ptr    <= r_rr_ptr;
        end
    end

    assign req_ready = ~r_buf_valid;
    assign cdb_num   = r_cdb_num;
    assign cdb_value = r_cdb_value;
    assign cdb_src   = r_cdb_src;
    assign busy      = r_busy;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int TW = 3;
    localparam int XW = 32;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            flush     = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*TW-1:0] req_tag   = '0;
    logic [N*XW-1:0] req_value = '0;
    logic [N-1:0]    req_ready;
    logic [TW-1:0]   cdb_num;
    logic [XW-1:0]   cdb_value;
    logic [N-1:0]    cdb_src;
    logic            busy;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .XLEN(XW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .req_ready (req_ready),
        .cdb_num   (cdb_num),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: pending list + start pointer ----------
    bit            m_pv  [N];
    logic [TW-1:0] m_pt  [N];
    logic [XW-1:0] m_pval[N];
    int            m_ptr  = 0;
    logic [TW-1:0] e_num  = '0;
    logic [XW-1:0] e_val  = '0;
    logic [N-1:0]  e_src  = '0;
    logic [N-1:0]  e_ready = '1;
    logic          e_busy = 1'b0;

    task automatic model_step();
        bit            cv[N];
        logic [TW-1:0] ct[N];
        logic [XW-1:0] cval[N];
        int            win;
        if (flush) begin
            for (int i = 0; i < N; i++) m_pv[i] = 1'b0;
            e_num = '0;
            e_src = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cv[i] = 1'b0; ct[i] = '0; cval[i] = '0;
                if (m_pv[i]) begin
                    cv[i] = 1'b1; ct[i] = m_pt[i]; cval[i] = m_pval[i];
                end else if (req_valid[i] && req_tag[i*TW +: TW] != '0) begin
                    cv[i] = 1'b1; ct[i] = req_tag[i*TW +: TW]; cval[i] = req_value[i*XW +: XW];
                end
            end
            win = -1;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && cv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            e_src = '0;
            if (win >= 0) begin
                e_num = ct[win];
                e_val = cval[win];
                e_src[win] = 1'b1;
                m_ptr = (win + 1) % N;
            end else begin
                e_num = '0;
            end
            for (int i = 0; i < N; i++) begin
                m_pv[i]   = cv[i] && (i != win);
                m_pt[i]   = ct[i];
                m_pval[i] = cval[i];
            end
        end
        e_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_ready[i] = !m_pv[i];
            if (m_pv[i]) e_busy = 1'b1;
        end
    endtask

    initial begin : model
        for (int i = 0; i < N; i++) m_pv[i] = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < N; i++) m_pv[i] = 1'b0;
                m_ptr = 0; e_num = '0; e_val = '0; e_src = '0; e_ready = '1; e_busy = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- per-cycle compare against the model ---------------------
    always @(negedge clk) begin
        if (rst) begin
            chk("model_num",   64'(cdb_num),   64'(e_num));
            chk("model_src",   64'(cdb_src),   64'(e_src));
            chk("model_ready", 64'(req_ready), 64'(e_ready));
            chk("model_busy",  64'(busy),      64'(e_busy));
            if (e_num != '0) chk("model_value", 64'(cdb_value), 64'(e_val));
        end
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic drive(input int i, input logic [TW-1:0] t, input logic [XW-1:0] v);
        req_valid[i]         = 1'b1;
        req_tag[i*TW +: TW]  = t;
        req_value[i*XW +: XW] = v;
    endtask

    task automatic idle_in();
        req_valid = '0;
        req_tag   = '0;
        req_value = '0;
        flush     = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input string name, input logic [TW-1:0] n, input logic [N-1:0] s);
        chk({name, "_num"}, 64'(cdb_num), 64'(n));
        chk({name, "_src"}, 64'(cdb_src), 64'(s));
    endtask

    // ---------------- directed sequence ---------------------------------------
    initial begin
        #1 rst = 1'b0;
        #1;
        chk("reset_num",   64'(cdb_num),   64'h0);
        chk("reset_value", 64'(cdb_value), 64'h0);
        chk("reset_src",   64'(cdb_src),   64'h0);
        chk("reset_busy",  64'(busy),      64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("ready_after_reset", 64'(req_ready), 64'h7);

        // Single ALU result, 1-cycle latency, ready never drops
        drive(0, 3'd3, 32'h0000_0042);
        cyc(); idle_in();
        bus("single", 3'd3, 3'b001);
        chk("single_value", 64'(cdb_value), 64'h42);
        chk("single_ready", 64'(req_ready), 64'h7);
        cyc();
        bus("single_idle", 3'd0, 3'b000);
        chk("single_ready2", 64'(req_ready), 64'h7);

        // Grant requester 2 alone so the pointer wraps back to 0
        drive(2, 3'd7, 32'h77);
        cyc(); idle_in();
        bus("wrap", 3'd7, 3'b100);
        cyc();

        // Three-way collision from pointer 0
        drive(0, 3'd1, 32'hA); drive(1, 3'd2, 32'hB); drive(2, 3'd4, 32'hC);
        cyc(); idle_in();
        bus("coll1", 3'd1, 3'b001);
        chk("coll1_value", 64'(cdb_value), 64'hA);
        chk("coll1_ready", 64'(req_ready), 64'h1);
        chk("coll1_busy",  64'(busy),      64'h1);
        cyc();
        bus("coll2", 3'd2, 3'b010);
        chk("coll2_value", 64'(cdb_value), 64'hB);
        chk("coll2_ready", 64'(req_ready), 64'h3);
        cyc();
        bus("coll3", 3'd4, 3'b100);
        chk("coll3_value", 64'(cdb_value), 64'hC);
        chk("coll3_ready", 64'(req_ready), 64'h7);
        chk("coll3_busy",  64'(busy),      64'h0);
        cyc();
        bus("coll_idle", 3'd0, 3'b000);

        // Rotation: grant 0 moves pointer to 1; 0 and 1 collide -> 1 first
        drive(0, 3'd5, 32'h55);
        cyc(); idle_in();
        bus("rot_a", 3'd5, 3'b001);
        drive(0, 3'd6, 32'h66); drive(1, 3'd2, 32'h22);
        cyc(); idle_in();
        bus("rot_b", 3'd2, 3'b010);
        drive(2, 3'd3, 32'h33);          // pointer is now 2: beats buffered requester 0
        cyc(); idle_in();
        bus("rot_c", 3'd3, 3'b100);
        cyc();
        bus("rot_d", 3'd6, 3'b001);
        chk("rot_d_value", 64'(cdb_value), 64'h66);
        cyc();

        // Tag 0 is not a result
        req_valid[1] = 1'b1; req_value[XW +: XW] = 32'h99;
        cyc(); idle_in();
        bus("tag0", 3'd0, 3'b000);
        chk("tag0_ready", 64'(req_ready), 64'h7);
        chk("tag0_busy",  64'(busy),      64'h0);

        // Flush with two buffered and one incoming (pointer is 1)
        drive(0, 3'd1, 32'h1); drive(1, 3'd2, 32'h2); drive(2, 3'd3, 32'h3);
        cyc(); idle_in();
        bus("pre_flush", 3'd2, 3'b010);
        chk("pre_flush_busy", 64'(busy), 64'h1);
        drive(1, 3'd5, 32'h5); flush = 1'b1;
        cyc(); idle_in();
        bus("flush", 3'd0, 3'b000);
        chk("flush_busy",  64'(busy),      64'h0);
        chk("flush_ready", 64'(req_ready), 64'h7);
        repeat (3) begin
            cyc();
            bus("post_flush", 3'd0, 3'b000);
        end
        drive(0, 3'd6, 32'h6); drive(2, 3'd7, 32'h7);   // pointer kept at 2
        cyc(); idle_in();
        bus("flush_ptr", 3'd7, 3'b100);
        cyc();
        bus("flush_ptr2", 3'd6, 3'b001);
        cyc();

        // Asynchronous reset while tag 5 is on the bus
        drive(1, 3'd5, 32'h5555);
        cyc(); idle_in();
        bus("pre_rst", 3'd5, 3'b010);
        #2 rst = 1'b0;
        #1;
        bus("async_rst", 3'd0, 3'b000);
        chk("async_rst_value", 64'(cdb_value), 64'h0);
        chk("async_rst_busy",  64'(busy),      64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        drive(2, 3'd6, 32'h6666);
        cyc(); idle_in();
        bus("after_rst", 3'd6, 3'b100);
        chk("after_rst_value", 64'(cdb_value), 64'h6666);
        cyc();
        bus("after_rst_idle", 3'd0, 3'b000);

        // Mixed traffic checked cycle by cycle against the model
        for (int c = 0; c < 80; c++) begin
            idle_in();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1)
                    drive(i, TW'($urandom_range(0, 7)), $urandom);
            end
            flush = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle_in();
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
